// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and constants shared by the UART transmit and receive word buffers.
//   BYTES_PER_WORD : bytes packed into one FIFO word
//   byte_t         : one UART byte
//   word_t         : one FIFO word (MSB-first packing of BYTES_PER_WORD bytes)
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

endpackage : uart_pkg

// File: rtl/word_assembler.sv
// word_assembler
//   Packs a byte stream into 32-bit words, most significant byte first.
//   Ports:
//     CLK         : system clock, rising edge
//     reset       : synchronous active-high reset, drops any partial word
//     input_data  : received byte, sampled when input_valid is high
//     input_valid : one-cycle strobe per received byte
//     o_word      : completed word, meaningful while o_push is high
//     o_push      : one-cycle push request, high in the cycle of the last byte
module word_assembler
  import uart_pkg::*;
(
  input  logic  CLK,
  input  logic  reset,
  input  byte_t input_data,
  input  logic  input_valid,
  output word_t o_word,
  output logic  o_push
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_partial;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_partial  <= '0;
    end else if (input_valid) begin
      if (r_byte_cnt == LAST_BYTE) begin
        // Word completes this cycle; the partial register is fully
        // overwritten by the next three bytes, so it is left as is.
        r_byte_cnt <= '0;
      end else begin
        r_partial  <= {r_partial[15:0], input_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end
  end

  // The push is issued combinationally with the last byte so the FIFO
  // captures the word on the same edge; it is visible one cycle later.
  assign o_push = input_valid && (r_byte_cnt == LAST_BYTE);
  assign o_word = {r_partial, input_data};

endmodule : word_assembler

// File: rtl/receiver_buffer.sv
// receiver_buffer
//   Receive-side word buffer: assembles UART bytes into 32-bit words and
//   queues them in a first-word-fall-through circular FIFO.
//   Ports:
//     CLK         : system clock, rising edge
//     reset       : synchronous active-high reset (priority over all inputs)
//     input_data  : received byte
//     input_valid : one-cycle strobe per received byte
//     read_enable : pop request; ignored while the FIFO is empty
//     data        : word at FIFO head, 0 while empty
//     valid       : FIFO non-empty
//     ready       : FIFO not full
//     level       : number of stored words
//     overflow    : sticky, set when a completed word had to be dropped
module receiver_buffer
  import uart_pkg::*;
#(
  parameter int BUFFER_SIZE = 32
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  byte_t                        input_data,
  input  logic                         input_valid,
  input  logic                         read_enable,
  output word_t                        data,
  output logic                         valid,
  output logic                         ready,
  output logic [$clog2(BUFFER_SIZE):0] level,
  output logic                         overflow
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(BUFFER_SIZE);

  word_t         r_mem [BUFFER_SIZE];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  word_t w_word;
  logic  w_push;
  logic  w_pop_ok;
  logic  w_push_ok;
  logic  w_empty;
  logic  w_full;

  word_assembler u_assembler (
    .CLK         (CLK),
    .reset       (reset),
    .input_data  (input_data),
    .input_valid (input_valid),
    .o_word      (w_word),
    .o_push      (w_push)
  );

  // Full/empty come from the occupancy count only; head == tail is
  // ambiguous between the two.
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LEVEL);
  assign w_pop_ok  = read_enable && !w_empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign w_push_ok = w_push && (!w_full || w_pop_ok);

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (w_push_ok && !reset) begin
      r_mem[r_tail] <= w_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop_ok) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign valid    = !w_empty;
  assign ready    = !w_full;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign data     = w_empty ? '0 : r_mem[r_head];

endmodule : receiver_buffer
